mem_arbiter: RTL

Two-master, one-slave arbiter. It shares a single unified memory port between the instruction fetch path (IFU) and the load/store path (LSU) of the multi-cycle RV32 core, replacing the separate inst_mem/data_mem instances. Each master uses a valid/ready request channel and a single-cycle response pulse. The downstream port has variable latency, with a watchdog that reports an error if a response never arrives.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) round-robin arbiter onto one variable-latency memory port,
// with a response watchdog that completes the owner with an error on timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  output logic              ifu_resp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              lsu_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned MASK_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic {M_IFU, M_LSU} master_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

  state_t            state_q, state_d;
  master_t           owner_q, owner_d;
  master_t           last_q, last_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_valid_d;
  logic              ifu_rv_d, lsu_rv_d;
  logic              ifu_err_d, lsu_err_d;
  logic [DATA_W-1:0] ifu_data_d, lsu_data_d;
  logic              grant_ifu, grant_lsu;
  logic              done, done_err;

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign mem_addr      = req_q.addr;
  assign mem_wen       = req_q.wen;
  assign mem_wdata     = req_q.wdata;
  assign mem_wmask     = req_q.wmask;

  // Next-state, arbitration and completion logic.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_d          = last_q;
    req_d           = req_q;
    cnt_d           = cnt_q;
    mem_req_valid_d = 1'b0;
    ifu_rv_d        = 1'b0;
    lsu_rv_d        = 1'b0;
    ifu_err_d       = ifu_resp_err;
    lsu_err_d       = lsu_resp_err;
    ifu_data_d      = ifu_resp_data;
    lsu_data_d      = lsu_resp_data;
    grant_ifu       = 1'b0;
    grant_lsu       = 1'b0;
    done            = 1'b0;
    done_err        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ready is gated by reset so nothing handshakes while held in reset.
        if (rst) begin
          if (ifu_req_valid && lsu_req_valid) begin
            grant_lsu = (last_q == M_IFU);
            grant_ifu = (last_q == M_LSU);
          end else begin
            grant_ifu = ifu_req_valid;
            grant_lsu = lsu_req_valid;
          end
        end
        if (grant_ifu) begin
          owner_d         = M_IFU;
          last_d          = M_IFU;
          req_d.addr      = ifu_addr;
          req_d.wen       = 1'b0;
          req_d.wdata     = '0;
          req_d.wmask     = '0;
          mem_req_valid_d = 1'b1;
          state_d         = S_REQ;
        end else if (grant_lsu) begin
          owner_d         = M_LSU;
          last_d          = M_LSU;
          req_d.addr      = lsu_addr;
          req_d.wen       = lsu_wen;
          req_d.wdata     = lsu_wdata;
          req_d.wmask     = lsu_wmask;
          mem_req_valid_d = 1'b1;
          state_d         = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid_d = 1'b1;
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          cnt_d           = '0;
          state_d         = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_resp_valid) begin
          done = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Stores and timeouts complete with zero data.
    if (done) begin
      if (owner_q == M_LSU) begin
        lsu_rv_d   = 1'b1;
        lsu_err_d  = done_err;
        lsu_data_d = (done_err || req_q.wen) ? '0 : mem_resp_data;
      end else begin
        ifu_rv_d   = 1'b1;
        ifu_err_d  = done_err;
        ifu_data_d = done_err ? '0 : mem_resp_data;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      owner_q        <= M_IFU;
      last_q         <= M_IFU;
      req_q          <= '0;
      cnt_q          <= '0;
      mem_req_valid  <= 1'b0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_data  <= '0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_data  <= '0;
      lsu_resp_err   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      req_q          <= req_d;
      cnt_q          <= cnt_d;
      mem_req_valid  <= mem_req_valid_d;
      ifu_resp_valid <= ifu_rv_d;
      ifu_resp_data  <= ifu_data_d;
      ifu_resp_err   <= ifu_err_d;
      lsu_resp_valid <= lsu_rv_d;
      lsu_resp_data  <= lsu_data_d;
      lsu_resp_err   <= lsu_err_d;
    end
  end

endmodule
